// File: rtl/can_bit_destuffing.sv
// CAN receive-side bit destuffer: removes the stuff bit after every STUFF_LEN equal bits,
// flags stuff errors and assembles DATA_W destuffed bits MSB-first into word_out.
module can_bit_destuffing #(
    parameter int DATA_W    = 64,
    parameter int STUFF_LEN = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        bit_en,
    input  logic                        rx_bit,
    input  logic                        stuff_off,
    output logic                        bit_out,
    output logic                        bit_out_valid,
    output logic [DATA_W-1:0]           word_out,
    output logic                        word_valid,
    output logic [$clog2(DATA_W+1)-1:0] bit_count,
    output logic                        stuff_err,
    output logic                        busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int RUN_W = $clog2(STUFF_LEN + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [RUN_W-1:0]  run_len_q, run_len_d;
    logic              last_bit_q, last_bit_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_out_valid_q, bit_out_valid_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              stuff_err_q, stuff_err_d;
    logic              accept;

    always_comb begin
        state_d         = state_q;
        run_len_d       = run_len_q;
        last_bit_d      = last_bit_q;
        bit_out_d       = bit_out_q;
        bit_out_valid_d = 1'b0;
        word_d          = word_q;
        word_valid_d    = 1'b0;
        count_d         = count_q;
        stuff_err_d     = stuff_err_q;
        accept          = 1'b0;

        // start wins over a coincident bit_en, so that bit is dropped
        if (start) begin
            state_d     = S_RUN;
            run_len_d   = '0;
            word_d      = '0;
            count_d     = '0;
            stuff_err_d = 1'b0;
        end else if (state_q == S_RUN && bit_en) begin
            if (stuff_off) begin
                accept    = 1'b1;
                run_len_d = '0;
            end else if (run_len_q == '0) begin
                accept     = 1'b1;
                last_bit_d = rx_bit;
                run_len_d  = RUN_W'(1);
            end else if (run_len_q == RUN_W'(STUFF_LEN)) begin
                if (rx_bit != last_bit_q) begin
                    // stuff bit is discarded but opens the next run
                    last_bit_d = rx_bit;
                    run_len_d  = RUN_W'(1);
                end else begin
                    stuff_err_d = 1'b1;
                    state_d     = S_ERROR;
                end
            end else begin
                accept     = 1'b1;
                last_bit_d = rx_bit;
                run_len_d  = (rx_bit == last_bit_q) ? run_len_q + RUN_W'(1) : RUN_W'(1);
            end

            if (accept) begin
                word_d          = {word_q[DATA_W-2:0], rx_bit};
                count_d         = count_q + CNT_W'(1);
                bit_out_d       = rx_bit;
                bit_out_valid_d = 1'b1;
                if (count_q == CNT_W'(DATA_W - 1)) begin
                    word_valid_d = 1'b1;
                    state_d      = S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            run_len_q       <= '0;
            last_bit_q      <= 1'b0;
            bit_out_q       <= 1'b0;
            bit_out_valid_q <= 1'b0;
            word_q          <= '0;
            word_valid_q    <= 1'b0;
            count_q         <= '0;
            stuff_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            run_len_q       <= run_len_d;
            last_bit_q      <= last_bit_d;
            bit_out_q       <= bit_out_d;
            bit_out_valid_q <= bit_out_valid_d;
            word_q          <= word_d;
            word_valid_q    <= word_valid_d;
            count_q         <= count_d;
            stuff_err_q     <= stuff_err_d;
        end
    end

    assign bit_out       = bit_out_q;
    assign bit_out_valid = bit_out_valid_q;
    assign word_out      = word_q;
    assign word_valid    = word_valid_q;
    assign bit_count     = count_q;
    assign stuff_err     = stuff_err_q;
    assign busy          = (state_q == S_RUN);

endmodule

// File: tb/tb_can_bit_destuffing.sv
// Directed bench for can_bit_destuffing: cycle table for short corner cases plus
// hand-written 64-bit frame sequences.
module tb_can_bit_destuffing;
    logic        clk = 1'b0;
    logic        rst, start, bit_en, rx_bit, stuff_off;
    logic        bit_out, bit_out_valid, word_valid, stuff_err, busy;
    logic [63:0] word_out;
    logic [6:0]  bit_count;

    int nvec = 0;
    int nerr = 0;

    localparam logic [63:0] PAT = 64'hA5A5_A5A5_A5A5_A5A5;

    can_bit_destuffing #(.DATA_W(64), .STUFF_LEN(5)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_en(bit_en), .rx_bit(rx_bit),
        .stuff_off(stuff_off), .bit_out(bit_out), .bit_out_valid(bit_out_valid),
        .word_out(word_out), .word_valid(word_valid), .bit_count(bit_count),
        .stuff_err(stuff_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, start, en, rx, soff;
        logic e_bov, e_bo, e_wv, e_err, e_busy;
        int   e_cnt;
        logic [63:0] e_word;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, s, e, x, o,
                                input logic bov, bo, wv, er, bz,
                                input int cnt, input logic [63:0] w);
        vec_t v;
        v = '{r, s, e, x, o, bov, bo, wv, er, bz, cnt, w};
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, s, e, x, o);
        rst = r; start = s; bit_en = e; rx_bit = x; stuff_off = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic b;
        int   acc;
        rst = 1'b1; start = 1'b0; bit_en = 1'b0; rx_bit = 1'b0; stuff_off = 1'b0;

        // reset, then 1,1,1,1,1,0,0,0,0,0,1 : stuff bits at idx5 and idx10
        add(1,0,0,0,0, 0,0,0,0,0, 0, 64'h0);
        add(0,1,0,0,0, 0,0,0,0,1, 0, 64'h0);
        add(0,0,1,1,0, 1,1,0,0,1, 1, 64'h1);
        add(0,0,1,1,0, 1,1,0,0,1, 2, 64'h3);
        add(0,0,1,1,0, 1,1,0,0,1, 3, 64'h7);
        add(0,0,1,1,0, 1,1,0,0,1, 4, 64'hF);
        add(0,0,1,1,0, 1,1,0,0,1, 5, 64'h1F);
        add(0,0,1,0,0, 0,1,0,0,1, 5, 64'h1F);
        add(0,0,1,0,0, 1,0,0,0,1, 6, 64'h3E);
        add(0,0,1,0,0, 1,0,0,0,1, 7, 64'h7C);
        add(0,0,1,0,0, 1,0,0,0,1, 8, 64'hF8);
        add(0,0,1,0,0, 1,0,0,0,1, 9, 64'h1F0);
        add(0,0,1,1,0, 0,0,0,0,1, 9, 64'h1F0);
        // six zeros: error on the sixth, later strobes ignored
        add(0,1,0,0,0, 0,0,0,0,1, 0, 64'h0);
        for (int k = 1; k <= 5; k++) add(0,0,1,0,0, 1,0,0,0,1, k, 64'h0);
        add(0,0,1,0,0, 0,0,0,1,0, 5, 64'h0);
        add(0,0,1,1,0, 0,0,0,1,0, 5, 64'h0);
        add(0,0,0,0,0, 0,0,0,1,0, 5, 64'h0);
        // stuff_off passes 8 ones, then a fresh checked run errors on its sixth one
        add(0,1,0,0,0, 0,0,0,0,1, 0, 64'h0);
        for (int k = 1; k <= 8; k++) add(0,0,1,1,1, 1,1,0,0,1, k, (64'h1 << k) - 64'h1);
        for (int k = 9; k <= 13; k++) add(0,0,1,1,0, 1,1,0,0,1, k, (64'h1 << k) - 64'h1);
        add(0,0,1,1,0, 0,1,0,1,0, 13, 64'h1FFF);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].start, tbl[i].en, tbl[i].rx, tbl[i].soff);
            chk($sformatf("row%0d bit_out_valid", i), 64'(bit_out_valid), 64'(tbl[i].e_bov));
            chk($sformatf("row%0d bit_out", i),       64'(bit_out),       64'(tbl[i].e_bo));
            chk($sformatf("row%0d word_valid", i),    64'(word_valid),    64'(tbl[i].e_wv));
            chk($sformatf("row%0d stuff_err", i),     64'(stuff_err),     64'(tbl[i].e_err));
            chk($sformatf("row%0d busy", i),          64'(busy),          64'(tbl[i].e_busy));
            chk($sformatf("row%0d bit_count", i),     64'(bit_count),     64'(tbl[i].e_cnt));
            chk($sformatf("row%0d word_out", i),      word_out,           tbl[i].e_word);
        end

        // 64 bits of A5 pattern, back-to-back strobes
        step(0,1,0,0,0);
        for (int i = 0; i < 64; i++) begin
            b = PAT[63-i];
            step(0,0,1,b,0);
            chk($sformatf("a5 bit%0d valid", i), 64'(bit_out_valid), 64'h1);
            chk($sformatf("a5 bit%0d value", i), 64'(bit_out), 64'(b));
            chk($sformatf("a5 bit%0d word_valid", i), 64'(word_valid), 64'(i == 63));
        end
        chk("a5 word_out", word_out, PAT);
        chk("a5 bit_count", 64'(bit_count), 64'd64);
        chk("a5 stuff_err", 64'(stuff_err), 64'h0);
        chk("a5 busy in DONE", 64'(busy), 64'h0);
        step(0,0,1,0,0);
        chk("done ignores bit_en valid", 64'(bit_out_valid), 64'h0);
        chk("done holds bit_count", 64'(bit_count), 64'd64);
        chk("done holds word_out", word_out, PAT);

        // all ones, stuffed 11111 0 ...; 76 strobes
        step(0,1,0,0,0);
        chk("ones start busy", 64'(busy), 64'h1);
        acc = 0;
        for (int i = 1; i <= 64; i++) begin
            step(0,0,1,1,0);
            chk($sformatf("ones bit%0d valid", i), 64'(bit_out_valid), 64'h1);
            chk($sformatf("ones bit%0d word_valid", i), 64'(word_valid), 64'(i == 64));
            if (bit_out_valid === 1'b1) acc++;
            if (i % 5 == 0 && i < 64) begin
                step(0,0,1,0,0);
                chk($sformatf("ones stuff after %0d", i), 64'(bit_out_valid), 64'h0);
                if (bit_out_valid === 1'b1) acc++;
            end
        end
        chk("ones accepted", 64'(acc), 64'd64);
        chk("ones word_out", word_out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ones bit_count", 64'(bit_count), 64'd64);
        chk("ones stuff_err", 64'(stuff_err), 64'h0);

        // start colliding with bit_en drops that bit; then rst clears everything
        step(0,1,0,0,0);
        for (int i = 0; i < 20; i++) step(0,0,1,PAT[63-i],0);
        chk("pre-restart bit_count", 64'(bit_count), 64'd20);
        step(0,1,1,1,0);
        chk("restart bit_count", 64'(bit_count), 64'h0);
        chk("restart word_out", word_out, 64'h0);
        chk("restart valid", 64'(bit_out_valid), 64'h0);
        chk("restart busy", 64'(busy), 64'h1);
        for (int i = 0; i < 20; i++) step(0,0,1,PAT[63-i],0);
        chk("post-restart bit_count", 64'(bit_count), 64'd20);
        chk("post-restart word_out", word_out, 64'(PAT[63:44]));
        step(1,0,1,1,0);
        chk("rst bit_out", 64'(bit_out), 64'h0);
        chk("rst valid", 64'(bit_out_valid), 64'h0);
        chk("rst word_out", word_out, 64'h0);
        chk("rst word_valid", 64'(word_valid), 64'h0);
        chk("rst bit_count", 64'(bit_count), 64'h0);
        chk("rst stuff_err", 64'(stuff_err), 64'h0);
        chk("rst busy", 64'(busy), 64'h0);
        step(0,0,1,1,0);
        chk("idle ignores bit_en count", 64'(bit_count), 64'h0);
        chk("idle ignores bit_en valid", 64'(bit_out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
